// File: rtl/pc_sequencer_pkg.sv
// Shared core definitions for the fetch-stage PC sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_sequencer_pkg;

    localparam int XLEN = 32;

    // Every instruction is one 32-bit word.
    localparam logic [XLEN-1:0] INSN_BYTES = 32'd4;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_TRAP_VEC = 32'h0000_0080;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC: trap > branch > jump > sequential > hold.
// Latency: purely combinational.
// Backpressure: none; acceptance arrives already qualified by stall/imem_ready.
module pc_next_mux
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap_en,
    input  logic            br_en,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp_en,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            accept,
    output logic [XLEN-1:0] pc_nxt,
    output logic            redirect
);

    // Older instructions win: trap, then EX-stage branch, then ID-stage jump.
    always_comb begin
        pc_nxt   = pc;
        redirect = 1'b0;
        if (trap_en) begin
            pc_nxt   = TRAP_VEC;
            redirect = 1'b1;
        end else if (br_en) begin
            pc_nxt   = br_target;
            redirect = 1'b1;
        end else if (jmp_en) begin
            pc_nxt   = jmp_target;
            redirect = 1'b1;
        end else if (accept) begin
            pc_nxt   = pc + INSN_BYTES;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: sequential fetch, branch/jump/trap redirect, halt.
// Latency: redirect target and flush appear on pc the cycle after sampling.
// Backpressure: stall or !imem_ready holds pc; redirects override both.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            trap,
    input  logic            halt_req,
    input  logic            imem_ready,
    output logic [XLEN-1:0] pc,
    output logic            imem_req,
    output logic            if_valid,
    output logic            flush,
    output logic            halted,
    output logic [XLEN-1:0] fetch_cnt
);

    seq_state_t      state_q;
    seq_state_t      state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_nxt;
    logic            if_valid_q;
    logic            flush_q;
    logic [XLEN-1:0] fetch_cnt_q;
    logic            accept;
    logic            redirect;
    logic            trap_en;
    logic            br_en;
    logic            jmp_en;

    // Traps are honoured in RUN and HALT; branch/jump only while running.
    assign trap_en  = trap & (state_q != ST_BOOT);
    assign br_en    = br_taken & (state_q == ST_RUN);
    assign jmp_en   = jmp & (state_q == ST_RUN);

    // Request is combinational from state and stall so a stall bites immediately.
    assign imem_req = (state_q == ST_RUN) & ~stall;
    assign accept   = imem_req & imem_ready;

    pc_next_mux #(
        .TRAP_VEC (TRAP_VEC)
    ) u_next_mux (
        .pc         (pc_q),
        .trap_en    (trap_en),
        .br_en      (br_en),
        .br_target  (br_target),
        .jmp_en     (jmp_en),
        .jmp_target (jmp_target),
        .accept     (accept),
        .pc_nxt     (pc_nxt),
        .redirect   (redirect)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any redirect keeps or returns us to RUN, beating halt_req.
    always_comb begin
        state_d = state_q;
        halted  = 1'b0;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (!(trap_en | br_en | jmp_en) && halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                halted = 1'b1;
                if (trap_en) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // PC, fetch qualifier, flush pulse and accepted-fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q       <= pc_nxt;
            // A redirect in the same cycle squashes the fetch it overlaps.
            if_valid_q <= accept & ~redirect;
            flush_q    <= redirect;
            if (accept) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign pc        = pc_q;
    assign if_valid  = if_valid_q;
    assign flush     = flush_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule
